// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector (KMP state machine, run-time overlap select).
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module moore_seq_detector_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b0101,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ovl,
    input  logic             i,
    output logic             f
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int SW = (LEN < 1) ? 1 : $clog2(LEN + 1);
    localparam int NS = 1 << SW;

    typedef logic [SW-1:0] s_t;

    localparam s_t S_IDLE = '0;
    localparam s_t S_FULL = s_t'(LEN);

    if (LEN < 1 || LEN > 16) begin : g_len_chk
        $error("moore_seq_detector_param: LEN=%0d outside legal range 1..16", LEN);
    end

    // Bit k of the sequence in arrival order; the MSB of PATTERN arrives first.
    function automatic bit pbit(input int k);
        return PATTERN[LEN-1-k];
    endfunction

    // Longest pattern prefix that is a suffix of (first s pattern bits, b).
    function automatic int adv(input int s, input bit b);
        int  res;
        bit  found;
        bit  ok;
        bit  cb;
        int  j;
        res   = 0;
        found = 1'b0;
        for (int k = s + 1; k >= 1; k--) begin
            if (!found && k <= LEN) begin
                ok = 1'b1;
                for (int m = 0; m < k; m++) begin
                    j  = s + 1 - k + m;
                    cb = (j < s) ? pbit(j) : b;
                    if (pbit(m) != cb) ok = 1'b0;
                end
                if (ok) begin
                    res   = k;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Longest proper prefix of the whole pattern that is also its suffix.
    function automatic int fail_full();
        int  res;
        bit  ok;
        res = 0;
        for (int k = 1; k < LEN; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                if (pbit(m) != pbit(LEN - k + m)) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    function automatic int nxt(input int s, input bit b, input bit o);
        int res;
        if (s < LEN)       res = adv(s, b);
        else if (s == LEN) res = o ? adv(fail_full(), b) : adv(0, b);
        else               res = 0;  // unreachable encodings fall back to idle
        return res;
    endfunction

    // Next-state table is elaboration-time constant: [state][input bit][ovl].
    s_t nxt_tbl [NS][2][2];

    for (genvar gs = 0; gs < NS; gs++) begin : g_s
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            for (genvar go = 0; go < 2; go++) begin : g_o
                localparam int N = nxt(gs, (gb != 0), (go != 0));
                assign nxt_tbl[gs][gb][go] = N[SW-1:0];
            end
        end
    end

    s_t s_q;
    s_t s_d;

    always_ff @(posedge clk) begin
        if (rst) s_q <= S_IDLE;
        else     s_q <= s_d;
    end

    always_comb begin
        s_d = s_q;
        f   = 1'b0;
        if (en) s_d = nxt_tbl[s_q][i][ovl];
        if (s_q == S_FULL) f = 1'b1;
    end

`ifdef MATCH_COUNT_EN
    // With en low the state holds, so en && s_d == LEN covers both entry and re-match.
    always_ff @(posedge clk) begin
        if (rst)
            match_cnt <= '0;
        else if (en && s_d == S_FULL && match_cnt != {CNT_W{1'b1}})
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule
